// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: op encodings,
// instruction-word field positions, sequencer state encoding and a decoder.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // Instruction word layout: [15:14] op, [13:11] y, [10:8] a, [7:5] b, [4:0] repeat
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 14;
    localparam int Y_MSB  = 13;
    localparam int Y_LSB  = 11;
    localparam int A_MSB  = 10;
    localparam int A_LSB  = 8;
    localparam int B_MSB  = 7;
    localparam int B_LSB  = 5;
    localparam int R_MSB  = 4;
    localparam int R_LSB  = 0;

    typedef logic [0:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 1'b0;
    localparam seq_state_t ST_ISSUE = 1'b1;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] y;
        logic [2:0] a;
        logic [2:0] b;
        logic [4:0] rpt;
    } instr_t;

    function automatic instr_t decode_instr(input logic [15:0] word);
        instr_t d;
        d.op  = word[OP_MSB:OP_LSB];
        d.y   = word[Y_MSB:Y_LSB];
        d.a   = word[A_MSB:A_LSB];
        d.b   = word[B_MSB:B_LSB];
        d.rpt = word[R_MSB:R_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// DEPTH x 16 instruction FIFO with synchronous reset. Push is ignored when
// full and pop is ignored when empty; simultaneous push/pop keeps the count.
module alu_instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import alu_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_s;
    logic          pop_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(0));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for the pointers and the occupancy count.
    always_comb begin
        push_s   = push && !full;
        pop_s    = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction-issue front end for the eight-register ALU: buffers words,
// issues each one R+1 cycles with held controls, captures sticky overflow
// and counts issued cycles.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [1:0]  op,
    output logic [2:0]  aindex,
    output logic [2:0]  bindex,
    output logic [2:0]  yindex,
    output logic        issue,
    input  logic        overflow,
    output logic        ovf_sticky,
    input  logic        ovf_clear,
    output logic        busy,
    output logic [15:0] issue_count
);
    import alu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t  state_q, state_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  yidx_q, yidx_d;
    logic [2:0]  aidx_q, aidx_d;
    logic [2:0]  bidx_q, bidx_d;
    logic        issue_dly_q;
    logic        sticky_q, sticky_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic [15:0]   fifo_rdata_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    instr_t        head_s;

    alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (in_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // in_ready depends only on FIFO state, so a full FIFO never accepts even
    // when the sequencer pops on the same edge.
    assign in_ready    = !fifo_full_s;
    assign fifo_push_s = in_valid && in_ready;
    assign head_s      = decode_instr(fifo_rdata_s);

    assign op          = op_q;
    assign yindex      = yidx_q;
    assign aindex      = aidx_q;
    assign bindex      = bidx_q;
    assign issue       = (state_q == ST_ISSUE);
    assign busy        = (fifo_count_s != CW'(0)) || issue;
    assign ovf_sticky  = sticky_q;
    assign issue_count = issue_cnt_q;

    // Issue FSM: load the head word on pop, count down repeats, reload
    // back-to-back with no gap cycle, fall back to IDLE when drained.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        op_d       = op_q;
        yidx_d     = yidx_q;
        aidx_d     = aidx_q;
        bidx_d     = bidx_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_d    = ST_ISSUE;
                    rem_d      = head_s.rpt;
                    op_d       = head_s.op;
                    yidx_d     = head_s.y;
                    aidx_d     = head_s.a;
                    bidx_d     = head_s.b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rem_q != 5'd0) begin
                    rem_d = rem_q - 5'd1;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    rem_d      = head_s.rpt;
                    op_d       = head_s.op;
                    yidx_d     = head_s.y;
                    aidx_d     = head_s.a;
                    bidx_d     = head_s.b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow (a set beats a coincident clear) and wrapping issue counter.
    always_comb begin
        if (issue_dly_q && overflow) begin
            sticky_d = 1'b1;
        end else if (ovf_clear) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
        if (issue) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rem_q       <= 5'd0;
            op_q        <= OP_ADD;
            yidx_q      <= 3'd0;
            aidx_q      <= 3'd0;
            bidx_q      <= 3'd0;
            issue_dly_q <= 1'b0;
            sticky_q    <= 1'b0;
            issue_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            yidx_q      <= yidx_d;
            aidx_q      <= aidx_d;
            bidx_q      <= bidx_d;
            issue_dly_q <= issue;
            sticky_q    <= sticky_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a queue-based behavioural model is
// compared every cycle, an ALU model drives overflow, and directed tests
// pin the model with hand-computed values.
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  op;
    logic [2:0]  aindex, bindex, yindex;
    logic        issue;
    logic        ovf_sticky;
    logic        ovf_clear;
    logic        busy;
    logic [15:0] issue_count;

    int checks = 0;
    int failures = 0;

    // ALU model
    logic [15:0] alu_r [8];
    logic        alu_ovf = 1'b0;
    logic        alu_ld = 1'b0;
    logic [2:0]  alu_ld_idx = 3'd0;
    logic [15:0] alu_ld_val = 16'd0;
    logic [31:0] alu_full_s;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .op          (op),
        .aindex      (aindex),
        .bindex      (bindex),
        .yindex      (yindex),
        .issue       (issue),
        .overflow    (alu_ovf),
        .ovf_sticky  (ovf_sticky),
        .ovf_clear   (ovf_clear),
        .busy        (busy),
        .issue_count (issue_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ALU combinational result
    always_comb begin
        alu_full_s = 32'd0;
        case (op)
            2'b00:   alu_full_s = {16'd0, alu_r[aindex]} + {16'd0, alu_r[bindex]};
            2'b01:   alu_full_s = {16'd0, alu_r[aindex]} - {16'd0, alu_r[bindex]};
            default: alu_full_s = {16'd0, alu_r[aindex]} * {16'd0, alu_r[bindex]};
        endcase
    end

    // ALU register file write and registered overflow
    always @(posedge CLK) begin
        if (alu_ld) alu_r[alu_ld_idx] <= alu_ld_val;
        else if (issue) alu_r[yindex] <= alu_full_s[15:0];
        alu_ovf <= issue && (alu_full_s[31:16] != 16'd0);
    end

    // ---------------- behavioural model ----------------
    logic [15:0] mq[$];
    logic [15:0] m_word = 16'd0;
    int          m_left = 0;
    logic        m_sticky = 1'b0;
    logic [15:0] m_count = 16'd0;
    logic        m_iprev = 1'b0;
    logic        m_valid = 1'b0;

    task automatic model_step();
        logic acc;
        logic cur;
        if (RST) begin
            mq.delete();
            m_word = 16'd0; m_left = 0; m_sticky = 1'b0;
            m_count = 16'd0; m_iprev = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            acc = in_valid && (mq.size() < DEPTH);
            cur = (m_left > 0);
            if (m_iprev && alu_ovf) m_sticky = 1'b1;
            else if (ovf_clear) m_sticky = 1'b0;
            if (cur) m_count = m_count + 16'd1;
            m_iprev = cur;
            if (m_left > 1) m_left = m_left - 1;
            else if (mq.size() > 0) begin
                m_word = mq.pop_front();
                m_left = int'(m_word[4:0]) + 1;
            end else m_left = 0;
            if (acc) mq.push_back(in_data);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Per-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                logic       e_rdy, e_iss, e_busy;
                logic [1:0] e_op;
                e_rdy  = (mq.size() < DEPTH);
                e_iss  = (m_left > 0);
                e_busy = (mq.size() > 0) || e_iss;
                e_op   = m_word[15:14];
                checks++;
                if (in_ready !== e_rdy || issue !== e_iss || op !== e_op ||
                    yindex !== m_word[13:11] || aindex !== m_word[10:8] ||
                    bindex !== m_word[7:5] || busy !== e_busy ||
                    ovf_sticky !== m_sticky || issue_count !== m_count) begin
                    failures++;
                    $display("FAIL model_cmp t=%0t act rdy/iss/op/y/a/b/busy/stk/cnt=%b/%b/%0d/%0d/%0d/%0d/%b/%b/%h exp=%b/%b/%0d/%0d/%0d/%0d/%b/%b/%h",
                             $time, in_ready, issue, op, yindex, aindex, bindex, busy, ovf_sticky, issue_count,
                             e_rdy, e_iss, e_op, m_word[13:11], m_word[10:8], m_word[7:5], e_busy, m_sticky, m_count);
                end
            end
        end
    end

    // Issue log for the ordering test
    logic [2:0] ylog[$];
    int         clog[$];
    int         cyc = 0;
    logic       log_en = 1'b0;
    logic       seen_full = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (log_en) begin
                if (issue) begin
                    ylog.push_back(yindex);
                    clog.push_back(cyc);
                end
                if (!in_ready) seen_full = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout word=%h act=in_ready_low exp=in_ready_high", w);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic alu_load(input logic [2:0] idx, input logic [15:0] val);
        alu_ld     = 1'b1;
        alu_ld_idx = idx;
        alu_ld_val = val;
        @(negedge CLK);
        alu_ld     = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle_timeout act=busy exp=idle");
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [2:0]  exp_y [13];
        logic [15:0] r7_before;
        int          bad;

        RST = 1'b1; in_valid = 1'b0; in_data = 16'd0; ovf_clear = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) alu_load(3'(i), 16'd0);
        alu_load(3'd1, 16'd1);
        alu_load(3'd2, 16'd1);
        RST = 1'b0;

        // Reset values
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_issue", {31'd0, issue}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_idx", {21'd0, op, yindex, aindex, bindex}, 32'd0);
        check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("rst_count", {16'd0, issue_count}, 32'd0);

        // Test 1: add y1=a1+b2, R=2
        push(16'h0942);
        check("t1_no_issue_yet", {31'd0, issue}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t1_issue", {31'd0, issue}, 32'd1);
            check("t1_ctrl", {21'd0, op, yindex, aindex, bindex}, {21'd0, 2'b00, 3'd1, 3'd1, 3'd2});
        end
        @(negedge CLK);
        check("t1_issue_end", {31'd0, issue}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_r1", {16'd0, alu_r[1]}, 32'd4);
        check("t1_count", {16'd0, issue_count}, 32'd3);

        // Test 2: long word then five R=0 words; FIFO fills, issue stays continuous
        for (int k = 0; k < 8; k++) exp_y[k] = 3'd7;
        for (int k = 8; k < 13; k++) exp_y[k] = 3'(k - 7);
        ylog.delete(); clog.delete(); seen_full = 1'b0;
        log_en = 1'b1;
        push(16'h3807);
        for (int k = 1; k <= 5; k++) push(16'(k) << 11);
        wait_idle(100);
        log_en = 1'b0;
        check("t2_seen_full", {31'd0, seen_full}, 32'd1);
        check("t2_issue_cycles", ylog.size(), 32'd13);
        if (ylog.size() == 13) begin
            check("t2_consecutive", clog[12] - clog[0], 32'd12);
            for (int k = 0; k < 13; k++) check("t2_order", {29'd0, ylog[k]}, {29'd0, exp_y[k]});
        end

        // Test 3: mul y3=a4*b4 overflows
        alu_load(3'd4, 16'd300);
        push(16'h9C80);
        @(negedge CLK);
        check("t3_issue", {31'd0, issue}, 32'd1);
        check("t3_ctrl", {21'd0, op, yindex, aindex, bindex}, {21'd0, 2'b10, 3'd3, 3'd4, 3'd4});
        check("t3_sticky_early", {31'd0, ovf_sticky}, 32'd0);
        @(negedge CLK);
        check("t3_alu_ovf", {31'd0, alu_ovf}, 32'd1);
        check("t3_sticky_write_edge", {31'd0, ovf_sticky}, 32'd0);
        @(negedge CLK);
        check("t3_sticky_set", {31'd0, ovf_sticky}, 32'd1);
        ovf_clear = 1'b1;
        @(negedge CLK);
        ovf_clear = 1'b0;
        check("t3_sticky_cleared", {31'd0, ovf_sticky}, 32'd0);
        push(16'h9C80);
        @(negedge CLK);
        @(negedge CLK);
        ovf_clear = 1'b1;
        @(negedge CLK);
        ovf_clear = 1'b0;
        check("t3_set_beats_clear", {31'd0, ovf_sticky}, 32'd1);
        wait_idle(20);

        // Test 4: reset in second cycle of an R=5 word with two queued words
        push(16'h3005);
        push(16'h3800);
        push(16'h2800);
        check("t4_issuing_before_rst", {31'd0, issue}, 32'd1);
        r7_before = alu_r[7];
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t4_issue_after_rst", {31'd0, issue}, 32'd0);
        check("t4_busy_after_rst", {31'd0, busy}, 32'd0);
        check("t4_ready_after_rst", {31'd0, in_ready}, 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (issue) bad++;
        end
        check("t4_no_issue_later", bad, 32'd0);
        check("t4_r7_untouched", {16'd0, alu_r[7]}, {16'd0, r7_before});

        // Test 5: issue-count wrap, 65534 + 3 issued cycles
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 2048; k++) push(16'h001F);
        push(16'h0000);
        wait_idle(600);
        check("t5_count_wrap", {16'd0, issue_count}, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-issue front end for the eight-register ALU. It accepts 16-bit ALU instruction words over a valid/ready handshake and buffers them in a small FIFO. It decodes each word into the ALU's `op`, `aindex`, `bindex` and `yindex` controls, issues each word for 1 to 32 consecutive cycles, and collects the ALU's registered `overflow` bit into a sticky flag. It sits between the instruction source (CPU core or debug loader) and the ALU.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the source presents `in_data`.
- `in_ready`  out  1  the FIFO can accept a word.
- `in_data`  in  16  instruction word: [15:14] op, [13:11] yindex, [10:8] aindex, [7:5] bindex, [4:0] repeat R.
- `op`  out  2  to ALU: 00 add, 01 sub, 1x mul.
- `aindex`, `bindex`, `yindex`  out  3 each  to ALU register selects.
- `issue`  out  1  ALU write enable. The ALU commits `yindex` only when this is high.
- `overflow`  in  1  registered overflow bit from the ALU.
- `ovf_sticky`  out  1  set by any overflow of an issued op; cleared by `ovf_clear`.
- `ovf_clear`  in  1  single-cycle clear of `ovf_sticky`.
- `busy`  out  1  FIFO non-empty or state ISSUE.
- `issue_count`  out  16  issued-cycle counter; wraps.

## Operation
- Handshake:
  - A word is accepted on an edge where `in_valid && in_ready`.
  - `in_ready` = FIFO count < `DEPTH`. It is registered-state derived and does not depend on `in_valid`.
  - There is no pass-through when full, even if a pop happens in the same cycle.
- State machine with states IDLE and ISSUE; register `rem` is 5 bits.
  - IDLE → ISSUE when the FIFO is non-empty. Pop the head, load op/indices into output registers, `rem` ← R.
  - In ISSUE with `rem` ≠ 0: `rem` decrements and the outputs hold.
  - In ISSUE with `rem` = 0:
    - FIFO non-empty: pop and reload, stay in ISSUE. Back-to-back words leave no gap cycle.
    - FIFO empty: go to IDLE.
- `issue` = (state == ISSUE). Each word is therefore issued exactly R+1 cycles with identical indices.
- In IDLE, op and the indices hold their last values and `issue` is 0.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Overflow capture:
  - `issue_d` is `issue` delayed one cycle.
  - On an edge with `issue_d && overflow`, `ovf_sticky` ← 1.
  - `ovf_clear` clears the flag. If a set and `ovf_clear` coincide, the set wins.
- `issue_count` increments on every edge where `issue` = 1. It wraps 0xFFFF → 0x0000.
- Reset values: `in_ready`=1 (FIFO empty), `op`=00, all indices 0, `issue`=0, `ovf_sticky`=0, `busy`=0, `issue_count`=0.
- Reset mid-operation:
  - Pending FIFO words and the remaining repeats are discarded.
  - `issue` is 0 from the reset edge onward.
  - ALU register contents are not touched.

## Timing
- Latency from accept to first issue:
  - Word accepted at edge t (FIFO was empty, state IDLE).
  - It is popped at edge t+1.
  - `issue` is high in cycles t+1 .. t+1+R.
  - The ALU writes at edges t+2 .. t+2+R.
- Overflow path:
  - The ALU `overflow` for the issue cycle ending at edge e is valid after e.
  - `ovf_sticky` rises at edge e+1.
- Dependencies: the ALU reads combinationally and writes on the edge. A result is visible to the next issued cycle with no stall, so the sequencer has no hazard logic.
- Sustained throughput: one issued op per cycle while the FIFO is non-empty.

## Structure
- Shared package `alu_pkg` holds:
  - op encodings `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_MUL`=2'b10;
  - field bit-position constants for op, y, a, b and R;
  - the IDLE/ISSUE state typedef.
- Sub-module `alu_instr_fifo`: parameterized `DEPTH` × 16, synchronous reset, with push/pop/full/empty/count.
- The top level holds the FSM, the output registers, `rem`, `issue_d`, the sticky flag and the counter.

## Test plan
- Reset, then `in_data`=0x0942 (add y1=a1+b2, R=2) at edge 1:
  - `issue` high exactly 3 cycles starting after edge 2, with op=00, y=1, a=1, b=2.
  - Then IDLE and `busy`=0.
  - With the ALU model at r1=r2=1, r1 ends at 4.
- Push five single-cycle words (R=0) back-to-back with DEPTH=4 and no stall:
  - `in_ready` drops when the FIFO is full.
  - `issue` stays high for 5 consecutive cycles.
  - The issue order matches the push order.
- 0x9C80 (mul y3=a4*b4) with the ALU model asserting `overflow`:
  - `ovf_sticky` rises one edge after the ALU write edge.
  - Asserting `ovf_clear` on the same edge as a new overflow leaves the flag at 1.
- Assert `RST` in the second cycle of an R=5 word with two more words queued:
  - `issue` is 0 from the reset edge.
  - `busy`=0, `in_ready`=1.
  - No queued word is issued afterward.
- Preload `issue_count` to 0xFFFE by issuing 65534 cycles, then issue 3 more:
  - `issue_count` reads 0x0001.
